// File: rtl/shader_pkg.sv
// Shared types for the scanline sequencer: FSM states, Q11.5 vertex, coordinate format.
package shader_pkg;

  localparam int COORD_W   = 16;
  localparam int FRAC_BITS = 5;
  localparam int Y_MAX_DEF = 479;

  typedef enum logic [3:0] {
    IDLE,
    SORT0,
    SORT1,
    SORT2,
    SETUP,
    ISSUE,
    WAIT_DONE,
    WAIT_RELEASE,
    EMIT,
    FINISH
  } state_e;

  typedef struct packed {
    logic signed [COORD_W-1:0] x;
    logic signed [COORD_W-1:0] y;
  } vertex_t;

endpackage

// File: rtl/vertex_cswap.sv
// Combinational compare-swap of two vertices by signed y; equal y keeps input order.
module vertex_cswap
  import shader_pkg::*;
(
  input  vertex_t a_i,
  input  vertex_t b_i,
  output vertex_t lo_o,
  output vertex_t hi_o
);

  logic swap;

  assign swap = $signed(b_i.y) < $signed(a_i.y);
  assign lo_o = swap ? b_i : a_i;
  assign hi_o = swap ? a_i : b_i;

endmodule

// File: rtl/scanline_sequencer.sv
// Per-triangle scanline walker: sorts vertices, drives the span engine per scanline, forwards spans
// over valid/ready (data held while stalled). Build with SCANLINE_CLIP_EN to clamp scanlines to 0..Y_MAX.
module scanline_sequencer
  import shader_pkg::*;
#(
  parameter int Y_MAX = Y_MAX_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               tri_valid_i,
  output logic               tri_ready_o,
  input  logic [COORD_W-1:0] v0_x_i,
  input  logic [COORD_W-1:0] v0_y_i,
  input  logic [COORD_W-1:0] v1_x_i,
  input  logic [COORD_W-1:0] v1_y_i,
  input  logic [COORD_W-1:0] v2_x_i,
  input  logic [COORD_W-1:0] v2_y_i,
  output logic               eng_start_o,
  output logic [COORD_W-1:0] eng_y_o,
  output logic [COORD_W-1:0] eng_pax_o,
  output logic [COORD_W-1:0] eng_pay_o,
  output logic [COORD_W-1:0] eng_pbx_o,
  output logic [COORD_W-1:0] eng_pby_o,
  output logic [COORD_W-1:0] eng_pcx_o,
  output logic [COORD_W-1:0] eng_pcy_o,
  output logic [COORD_W-1:0] eng_pdx_o,
  output logic [COORD_W-1:0] eng_pdy_o,
  input  logic               eng_done_i,
  input  logic [COORD_W-1:0] eng_xl_i,
  input  logic [COORD_W-1:0] eng_xr_i,
  output logic               span_valid_o,
  input  logic               span_ready_i,
  output logic [COORD_W-1:0] span_y_o,
  output logic [COORD_W-1:0] span_xl_o,
  output logic [COORD_W-1:0] span_xr_o,
  output logic               tri_done_o,
  output logic               busy_o
);

`ifdef SCANLINE_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  localparam logic signed [COORD_W:0] ROUND_UP = (COORD_W+1)'((1 << FRAC_BITS) - 1);

  state_e state_q, state_d;

  vertex_t v0_q, v1_q, v2_q;
  vertex_t pc_q, pd_q;
  vertex_t cs_a, cs_b, cs_lo, cs_hi;

  logic signed [COORD_W-1:0] y_cur_q, y_end_q;
  logic signed [COORD_W-1:0] y_first, y_last;
  logic signed [COORD_W:0]   top_rnd;
  logic signed [COORD_W+FRAC_BITS-1:0] y_cur_fx, mid_y_ext;
  logic                      upper_half;

  logic               eng_start_q;
  logic [COORD_W-1:0] eng_y_q;
  logic [COORD_W-1:0] span_y_q, span_xl_q, span_xr_q;

  // One compare-swap unit serves all three sort passes.
  always_comb begin
    cs_a = v0_q;
    cs_b = v1_q;
    if (state_q == SORT1) begin
      cs_a = v1_q;
      cs_b = v2_q;
    end
  end

  vertex_cswap u_cswap (
    .a_i  (cs_a),
    .b_i  (cs_b),
    .lo_o (cs_lo),
    .hi_o (cs_hi)
  );

  assign top_rnd = $signed({v0_q.y[COORD_W-1], v0_q.y}) + ROUND_UP;

  always_comb begin
    y_first = COORD_W'(top_rnd >>> FRAC_BITS);
    y_last  = $signed(v2_q.y) >>> FRAC_BITS;
    if (CLIP && (y_first < 0)) y_first = '0;
    if (CLIP && (y_last > Y_MAX)) y_last = COORD_W'(Y_MAX);
  end

  // Upper half uses top->mid until the scanline reaches mid.y; flat tops skip it.
  assign y_cur_fx   = {y_cur_q, {FRAC_BITS{1'b0}}};
  assign mid_y_ext  = {{FRAC_BITS{v1_q.y[COORD_W-1]}}, v1_q.y};
  assign upper_half = y_cur_fx < mid_y_ext;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:         if (tri_valid_i) state_d = SORT0;
      SORT0:        state_d = SORT1;
      SORT1:        state_d = SORT2;
      SORT2:        state_d = SETUP;
      SETUP:        state_d = (y_first > y_last) ? FINISH : ISSUE;
      ISSUE:        state_d = WAIT_DONE;
      WAIT_DONE:    if (eng_done_i) state_d = WAIT_RELEASE;
      WAIT_RELEASE: if (!eng_done_i) state_d = EMIT;
      EMIT:         if (span_ready_i) state_d = (y_cur_q == y_end_q) ? FINISH : ISSUE;
      FINISH:       state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  always_comb begin
    tri_ready_o  = (state_q == IDLE);
    busy_o       = (state_q != IDLE);
    span_valid_o = (state_q == EMIT);
    tri_done_o   = (state_q == FINISH);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v0_q        <= '0;
      v1_q        <= '0;
      v2_q        <= '0;
      pc_q        <= '0;
      pd_q        <= '0;
      y_cur_q     <= '0;
      y_end_q     <= '0;
      eng_start_q <= 1'b0;
      eng_y_q     <= '0;
      span_y_q    <= '0;
      span_xl_q   <= '0;
      span_xr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (tri_valid_i) begin
          v0_q <= vertex_t'({v0_x_i, v0_y_i});
          v1_q <= vertex_t'({v1_x_i, v1_y_i});
          v2_q <= vertex_t'({v2_x_i, v2_y_i});
        end
        SORT0, SORT2: begin
          v0_q <= cs_lo;
          v1_q <= cs_hi;
        end
        SORT1: begin
          v1_q <= cs_lo;
          v2_q <= cs_hi;
        end
        SETUP: begin
          y_cur_q <= y_first;
          y_end_q <= y_last;
        end
        ISSUE: begin
          eng_start_q <= 1'b1;
          eng_y_q     <= y_cur_q;
          pc_q        <= upper_half ? v0_q : v1_q;
          pd_q        <= upper_half ? v1_q : v2_q;
        end
        WAIT_DONE: if (eng_done_i) begin
          eng_start_q <= 1'b0;
          span_y_q    <= y_cur_q;
          span_xl_q   <= eng_xl_i;
          span_xr_q   <= eng_xr_i;
        end
        EMIT: if (span_ready_i && (y_cur_q != y_end_q)) begin
          y_cur_q <= y_cur_q + COORD_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign eng_start_o = eng_start_q;
  assign eng_y_o     = eng_y_q;
  assign eng_pax_o   = v0_q.x;
  assign eng_pay_o   = v0_q.y;
  assign eng_pbx_o   = v2_q.x;
  assign eng_pby_o   = v2_q.y;
  assign eng_pcx_o   = pc_q.x;
  assign eng_pcy_o   = pc_q.y;
  assign eng_pdx_o   = pd_q.x;
  assign eng_pdy_o   = pd_q.y;
  assign span_y_o    = span_y_q;
  assign span_xl_o   = span_xl_q;
  assign span_xr_o   = span_xr_q;

endmodule

// File: tb/tb_scanline_sequencer.sv
// Scoreboard bench for scanline_sequencer; the span-engine model answers xl = pcx>>5, xr = pdx>>5.
`timescale 1ns/1ps
module tb_scanline_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tri_valid = 1'b0;
  logic        tri_ready;
  logic [15:0] v0_x = '0, v0_y = '0, v1_x = '0, v1_y = '0, v2_x = '0, v2_y = '0;
  logic        eng_start;
  logic [15:0] eng_y, eng_pax, eng_pay, eng_pbx, eng_pby, eng_pcx, eng_pcy, eng_pdx, eng_pdy;
  logic        eng_done = 1'b0;
  logic [15:0] eng_xl = '0, eng_xr = '0;
  logic        span_valid;
  logic        span_ready = 1'b1;
  logic [15:0] span_y, span_xl, span_xr;
  logic        tri_done;
  logic        busy;

  always #5 clk = ~clk;

  scanline_sequencer dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .tri_valid_i  (tri_valid),
    .tri_ready_o  (tri_ready),
    .v0_x_i       (v0_x),
    .v0_y_i       (v0_y),
    .v1_x_i       (v1_x),
    .v1_y_i       (v1_y),
    .v2_x_i       (v2_x),
    .v2_y_i       (v2_y),
    .eng_start_o  (eng_start),
    .eng_y_o      (eng_y),
    .eng_pax_o    (eng_pax),
    .eng_pay_o    (eng_pay),
    .eng_pbx_o    (eng_pbx),
    .eng_pby_o    (eng_pby),
    .eng_pcx_o    (eng_pcx),
    .eng_pcy_o    (eng_pcy),
    .eng_pdx_o    (eng_pdx),
    .eng_pdy_o    (eng_pdy),
    .eng_done_i   (eng_done),
    .eng_xl_i     (eng_xl),
    .eng_xr_i     (eng_xr),
    .span_valid_o (span_valid),
    .span_ready_i (span_ready),
    .span_y_o     (span_y),
    .span_xl_o    (span_xl),
    .span_xr_o    (span_xr),
    .tri_done_o   (tri_done),
    .busy_o       (busy)
  );

  typedef struct {
    bit          is_done;
    logic [15:0] y;
    logic [15:0] xl;
    logic [15:0] xr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   start_cnt = 0;
  logic start_prev = 1'b0;
  int   lat_cfg = 2;
  int   lat_cnt = 0;

  // Span engine model: result after lat_cfg+1 cycles of start, done drops one cycle after start does.
  always @(posedge clk) begin
    if (!eng_start) begin
      eng_done <= 1'b0;
      lat_cnt  <= 0;
    end else if (!eng_done) begin
      if (lat_cnt >= lat_cfg) begin
        eng_done <= 1'b1;
        eng_xl   <= 16'($signed(eng_pcx) >>> 5);
        eng_xr   <= 16'($signed(eng_pdx) >>> 5);
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (eng_start && !start_prev) start_cnt++;
    start_prev = eng_start;
  end

  // Monitor: pops the scoreboard on every span handshake and every tri_done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && span_valid && span_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL span_unexpected actual y=%0d xl=%0d xr=%0d required none",
                 $signed(span_y), $signed(span_xl), $signed(span_xr));
      end else begin
        e = exp_q.pop_front();
        if (e.is_done || span_y !== e.y || span_xl !== e.xl || span_xr !== e.xr) begin
          failures++;
          $display("FAIL span actual y=%0d xl=%0d xr=%0d required done=%0b y=%0d xl=%0d xr=%0d",
                   $signed(span_y), $signed(span_xl), $signed(span_xr),
                   e.is_done, $signed(e.y), $signed(e.xl), $signed(e.xr));
        end
      end
    end
    if (rst_n && tri_done) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL tri_done_unexpected actual pulse required none");
      end else begin
        e = exp_q.pop_front();
        if (!e.is_done) begin
          failures++;
          $display("FAIL tri_done_early actual tri_done required span y=%0d", $signed(e.y));
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push_span(input int y, input int xl, input int xr);
    exp_t e;
    e.is_done = 1'b0;
    e.y  = 16'(y);
    e.xl = 16'(xl);
    e.xr = 16'(xr);
    exp_q.push_back(e);
  endtask

  task automatic push_done();
    exp_t e;
    e.is_done = 1'b1;
    e.y = '0;
    e.xl = '0;
    e.xr = '0;
    exp_q.push_back(e);
  endtask

  task automatic drive_vtx(input int ax, input int ay, input int bx, input int by,
                           input int cx, input int cy);
    v0_x = 16'(ax); v0_y = 16'(ay);
    v1_x = 16'(bx); v1_y = 16'(by);
    v2_x = 16'(cx); v2_y = 16'(cy);
  endtask

  task automatic send_tri(input int ax, input int ay, input int bx, input int by,
                          input int cx, input int cy);
    @(negedge clk);
    drive_vtx(ax, ay, bx, by, cx, cy);
    tri_valid = 1'b1;
    @(posedge clk);
    #1 tri_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!(tri_ready && exp_q.size() == 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual pending=%0d required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Triangle A: (0,10),(10,0),(20,10) px. Rows 0..9 use top->mid (x 10 -> 0), row 10 mid->bottom.
  task automatic push_tri_a();
    for (int y = 0; y < 10; y++) push_span(y, 10, 0);
    push_span(10, 0, 20);
    push_done();
  endtask

  task automatic send_tri_a();
    send_tri(0, 320, 320, 0, 640, 320);
  endtask

  initial begin
    int n;
    int c0;
    bit stable;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tri_ready", 32'(tri_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_eng_start", 32'(eng_start), 0);
    check("rst_span_valid", 32'(span_valid), 0);
    check("rst_tri_done", 32'(tri_done), 0);
    check("rst_span_y", 32'(span_y), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Scenario A with accept-to-start latency.
    push_tri_a();
    c0 = start_cnt;
    send_tri_a();
    n = 0;
    while (!eng_start && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    check("start_latency", 32'(n), 5);
    wait_idle("tri_a", 500);
    check("tri_a_starts", 32'(start_cnt - c0), 11);

    // Degenerate: all at y = 5.2 px, ceil 6 > floor 5.
    push_done();
    c0 = start_cnt;
    send_tri(0, 166, 100, 166, 200, 166);
    n = 0;
    while (!tri_done && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    check("flat_done_in_7", 32'(n <= 7), 1);
    wait_idle("flat", 100);
    check("flat_starts", 32'(start_cnt - c0), 0);

    // Backpressure on the first span.
    span_ready = 1'b0;
    push_tri_a();
    c0 = start_cnt;
    send_tri_a();
    n = 0;
    while (!span_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_span_valid_seen", 32'(span_valid), 1);
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!span_valid || span_y !== 16'd0 || eng_start) stable = 1'b0;
    end
    check("bp_hold_stable", 32'(stable), 1);
    span_ready = 1'b1;
    wait_idle("bp", 500);
    check("bp_starts", 32'(start_cnt - c0), 11);

    // Reset while waiting on a slow engine.
    lat_cfg = 20;
    send_tri_a();
    n = 0;
    while (!eng_start && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_eng_start", 32'(eng_start), 0);
    check("mid_rst_span_valid", 32'(span_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lat_cfg = 2;
    @(negedge clk);
    check("post_rst_tri_ready", 32'(tri_ready), 1);
    push_tri_a();
    c0 = start_cnt;
    send_tri_a();
    wait_idle("post_rst", 500);
    check("post_rst_starts", 32'(start_cnt - c0), 11);

    // Triangle B in scrambled order; a stray tri_valid arrives mid-run.
    for (int y = 1; y <= 3; y++) push_span(y, 0, 2);
    push_span(4, 2, 3);
    push_span(5, 2, 3);
    push_done();
    c0 = start_cnt;
    send_tri(96, 160, 0, 32, 64, 100);
    repeat (6) @(posedge clk);
    @(negedge clk);
    drive_vtx(0, 320, 320, 0, 640, 320);
    tri_valid = 1'b1;
    @(negedge clk);
    tri_valid = 1'b0;
    wait_idle("tri_b", 500);
    check("tri_b_starts", 32'(start_cnt - c0), 5);

    // Tall triangle crossing y < 0 and y > Y_MAX.
    c0 = start_cnt;
`ifdef SCANLINE_CLIP_EN
    for (int y = 0; y <= 479; y++) push_span(y, 0, 10);
    push_done();
    send_tri(0, -96, 320, 16000, 640, 16000);
    wait_idle("tall", 12000);
    check("tall_starts", 32'(start_cnt - c0), 480);
`else
    for (int y = -3; y <= 499; y++) push_span(y, 0, 10);
    push_span(500, 10, 20);
    push_done();
    send_tri(0, -96, 320, 16000, 640, 16000);
    wait_idle("tall", 12000);
    check("tall_starts", 32'(start_cnt - c0), 504);
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
